uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
Receive-side counterpart of the UART transmitter. It consumes the serial line driven by the transmitter's TX_OUT and oversamples it at PRESCALE× the bit rate. It recovers start, data, optional parity and stop bits, then presents the parallel byte with a one-cycle valid strobe and per-frame error flags. It sits between the RX pad/synchronizer and the system controller in the receive clock domain.

Parameters:
WIDTH, 8, data bits per frame (LSB first).

Ports:
CLK  input  1  receive clock, equal to PRESCALE × bit rate.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line, already synchronized; idle high.
PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  WIDTH  last good received word.
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
PAR_ERR  output  1  one-cycle pulse: parity mismatch, frame dropped.
STP_ERR  output  1  one-cycle pulse: stop bit sampled 0, frame dropped.

Behaviour:
- Reset: one clock, synchronous and active-high on RST. State=IDLE, all counters 0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. RST mid-frame aborts the frame with no pulses.
- PRESCALE: values other than 16/32 behave as 8. It is sampled only in IDLE and held for the whole frame.
- Counters: edge_cnt runs 0..P-1 in every non-IDLE state and wraps at P-1. bit_cnt advances on each wrap.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: in the first cycle RX_IN=0, that cycle is edge_cnt=0 of the start bit. Next state is START with edge_cnt=1.
- START: at edge_cnt=P-1:
  - sampled bit 1 → IDLE (glitch, no pulses).
  - otherwise → DATA, bit_cnt=0.
- DATA: at each edge_cnt=P-1, the sampled bit shifts into the shift register LSB first. After WIDTH bits → PARITY if PAR_EN=1, else STOP.
- PARITY: expected bit = XOR of the data bits XOR PAR_TYP. A mismatch is latched at edge_cnt=P-1. Then → STOP.
- STOP: at edge_cnt=P-1, evaluate the frame and return to IDLE next cycle:
  - no errors: P_DATA ← shift register and DATA_VALID=1 for exactly one cycle.
  - sampled stop bit 0: STP_ERR=1.
  - latched parity mismatch: PAR_ERR=1.
  - both errors: both pulses together. On any error P_DATA holds its old value and DATA_VALID stays 0.
- Latency: with start detected at cycle T0, the frame has N = WIDTH+2+PAR_EN bits. Pulses are registered and appear at cycle T0 + N·P.
- Back-to-back frames: IDLE accepts a new start on the same cycle the pulse is asserted. No dead cycle is required beyond the stop bit.
- PAR_EN and PAR_TYP are sampled at the START→DATA transition and held for the frame.
- A line stuck low after a stop error is treated as a new start bit. This is permitted.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 (LSB first, stop=1) → DATA_VALID pulse at T0+80, P_DATA=0xA5, no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → DATA_VALID at T0+176, P_DATA=0x3C. Repeat with parity 1 → PAR_ERR pulse at T0+176, P_DATA still 0x3C from the prior frame, no DATA_VALID.
- P=8, send 0x55 with stop bit 0 → STP_ERR at T0+80, P_DATA unchanged.
- Start glitch: RX_IN low for 2 cycles at P=16 → back to IDLE after 16 cycles, no pulses. A following valid 0x81 frame is received correctly.
- Majority vote: P=32, each data bit of 0xF0 has one of its three sample points forced to the opposite value → P_DATA=0xF0.
- Back-to-back: two frames 0x12, 0x34 at P=8 with no idle gap → two DATA_VALID pulses 80 cycles apart. Assert RST during bit 3 of a third frame → outputs reset, no pulses.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive core: oversamples RX_IN, recovers start/data/parity/stop bits with
// a 3-point majority vote, and emits a one-cycle valid or error pulse per frame.
module uart_rx_core #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [5:0]       PRESCALE,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state, state_nxt;
  logic [5:0]         edge_cnt;
  logic [5:0]         prescale_q;
  logic [5:0]         prescale_dec;
  logic [CNT_W-1:0]   bit_cnt;
  logic [2:0]         samples;
  logic [WIDTH-1:0]   shift_reg;
  logic               par_en_q;
  logic               par_typ_q;
  logic               par_err_q;
  logic               last_edge;
  logic               bit_val;
  logic [5:0]         mid;

  // Only 16 and 32 are honoured; every other code falls back to 8x.
  always_comb begin
    prescale_dec = 6'd8;
    if (PRESCALE == 6'd16 || PRESCALE == 6'd32) prescale_dec = PRESCALE;
  end

  assign mid       = prescale_q >> 1;
  assign last_edge = (edge_cnt == prescale_q - 6'd1);
  assign bit_val   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

  // NOTE: state register uses non-blocking assignment so every flop updates from
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START:  if (last_edge) state_nxt = bit_val ? IDLE : DATA;
      DATA: begin
        if (last_edge && bit_cnt == CNT_W'(WIDTH - 1))
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: if (last_edge) state_nxt = STOP;
      STOP:   if (last_edge) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt   <= '0;
      prescale_q <= 6'd8;
      bit_cnt    <= '0;
      samples    <= '0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      if (state == IDLE) begin
        // The cycle that sees the line low counts as edge 0 of the start bit.
        edge_cnt   <= RX_IN ? 6'd0 : 6'd1;
        prescale_q <= prescale_dec;
        bit_cnt    <= '0;
        par_err_q  <= 1'b0;
      end else begin
        edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;

        if (edge_cnt == mid - 6'd1) samples[0] <= RX_IN;
        if (edge_cnt == mid)        samples[1] <= RX_IN;
        if (edge_cnt == mid + 6'd1) samples[2] <= RX_IN;

        case (state)
          START: begin
            if (last_edge && !bit_val) begin
              par_en_q  <= PAR_EN;
              par_typ_q <= PAR_TYP;
              bit_cnt   <= '0;
            end
          end
          DATA: begin
            if (last_edge) begin
              shift_reg <= {bit_val, shift_reg[WIDTH-1:1]};
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            if (last_edge) par_err_q <= bit_val != ((^shift_reg) ^ par_typ_q);
          end
          STOP: begin
            if (last_edge) begin
              STP_ERR <= ~bit_val;
              PAR_ERR <= par_err_q;
              if (bit_val && !par_err_q) begin
                P_DATA     <= shift_reg;
                DATA_VALID <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
